// File: rtl/router_port_tx.sv
// rtl/router_port_tx.sv - serial packet transmitter (address, pad, payload; LSB first) for one router port.
// Optional ROUTER_TX_STATS_EN adds pkt_count, byte_count and sticky stall_seen outputs.
module router_port_tx #(
   parameter int ADDR_W     = 4,
   parameter int PAD_CYCLES = 5,
   parameter int GAP_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_da,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [7:0]        data_byte,
   input  logic              data_last,
   output logic              frame_n,
   output logic              valid_n,
   output logic              din,
   output logic              busy
`ifdef ROUTER_TX_STATS_EN
   ,
   output logic [15:0]       pkt_count,
   output logic [15:0]       byte_count,
   output logic              stall_seen
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_PAD, S_PAYLOAD, S_STALL, S_GAP
   } state_t;

   localparam logic [3:0] ADDR_LAST = 4'(ADDR_W - 1);
   localparam logic [3:0] PAD_LAST  = 4'(PAD_CYCLES - 1);
   localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] da_q, da_d;
   logic              frame_n_q, frame_n_d;
   logic              valid_n_q, valid_n_d;
   logic              din_q, din_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              data_ready_q, data_ready_d;
   logic              busy_q, busy_d;
   logic              accept;
   logic              load;

   assign accept = data_valid && data_ready_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         last_q       <= 1'b0;
         da_q         <= '0;
         frame_n_q    <= 1'b1;
         valid_n_q    <= 1'b1;
         din_q        <= 1'b0;
         cmd_ready_q  <= 1'b0;
         data_ready_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         last_q       <= last_d;
         da_q         <= da_d;
         frame_n_q    <= frame_n_d;
         valid_n_q    <= valid_n_d;
         din_q        <= din_d;
         cmd_ready_q  <= cmd_ready_d;
         data_ready_q <= data_ready_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      last_d  = last_q;
      da_d    = da_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d = S_ADDR;
               cnt_d   = '0;
               da_d    = cmd_da;
            end
         end
         S_ADDR: begin
            da_d = da_q >> 1;
            if (cnt_q == ADDR_LAST) begin
               state_d = S_PAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_PAD: begin
            if (cnt_q == PAD_LAST) begin
               if (accept) begin
                  state_d = S_PAYLOAD;
                  load    = 1'b1;
               end else begin
                  state_d = S_STALL;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_PAYLOAD: begin
            shift_d = shift_q >> 1;
            if (bit_q == 3'd7) begin
               if (last_q) begin
                  state_d = S_GAP;
                  cnt_d   = '0;
               end else if (accept) begin
                  load = 1'b1;
               end else begin
                  state_d = S_STALL;
               end
            end else begin
               bit_d = bit_q + 3'd1;
            end
         end
         S_STALL: begin
            if (accept) begin
               state_d = S_PAYLOAD;
               load    = 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (load) begin
         shift_d = data_byte;
         last_d  = data_last;
         bit_d   = '0;
      end
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      frame_n_d    = 1'b1;
      valid_n_d    = 1'b1;
      din_d        = 1'b0;
      cmd_ready_d  = 1'b0;
      data_ready_d = 1'b0;
      busy_d       = (state_d != S_IDLE);
      case (state_d)
         S_IDLE: cmd_ready_d = 1'b1;
         S_ADDR: begin
            frame_n_d = 1'b0;
            din_d     = da_d[0];
         end
         S_PAD: begin
            frame_n_d    = 1'b0;
            din_d        = 1'b1;
            data_ready_d = (cnt_d == PAD_LAST);
         end
         S_PAYLOAD: begin
            frame_n_d    = (bit_d == 3'd7) && last_d;
            valid_n_d    = 1'b0;
            din_d        = shift_d[0];
            data_ready_d = (bit_d == 3'd7) && !last_d;
         end
         S_STALL: begin
            frame_n_d    = 1'b0;
            din_d        = 1'b1;
            data_ready_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign cmd_ready  = cmd_ready_q;
   assign data_ready = data_ready_q;
   assign frame_n    = frame_n_q;
   assign valid_n    = valid_n_q;
   assign din        = din_q;
   assign busy       = busy_q;

`ifdef ROUTER_TX_STATS_EN
   logic [15:0] pkt_count_q, byte_count_q;
   logic        stall_seen_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_count_q  <= '0;
         byte_count_q <= '0;
         stall_seen_q <= 1'b0;
      end else begin
         if (state_q == S_PAYLOAD && bit_q == 3'd7 && last_q) begin
            pkt_count_q <= pkt_count_q + 16'd1;
         end
         if (accept) begin
            byte_count_q <= byte_count_q + 16'd1;
         end
         if (state_d == S_STALL) begin
            stall_seen_q <= 1'b1;
         end
      end
   end

   assign pkt_count  = pkt_count_q;
   assign byte_count = byte_count_q;
   assign stall_seen = stall_seen_q;
`endif

endmodule

// File: tb/tb_router_port_tx.sv
// tb/tb_router_port_tx.sv - scoreboard bench for router_port_tx; frames are decoded back to address and bytes.
module tb_router_port_tx;
   localparam int ADDR_W     = 4;
   localparam int PAD_CYCLES = 5;
   localparam int GAP_CYCLES = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_da = '0;
   logic       data_valid = 1'b0;
   logic       data_ready;
   logic [7:0] data_byte = '0;
   logic       data_last = 1'b0;
   logic       frame_n, valid_n, din, busy;
`ifdef ROUTER_TX_STATS_EN
   logic [15:0] pkt_count, byte_count;
   logic        stall_seen;
`endif

   router_port_tx #(.ADDR_W(ADDR_W), .PAD_CYCLES(PAD_CYCLES), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_da(cmd_da),
      .data_valid(data_valid), .data_ready(data_ready), .data_byte(data_byte), .data_last(data_last),
      .frame_n(frame_n), .valid_n(valid_n), .din(din), .busy(busy)
`ifdef ROUTER_TX_STATS_EN
      , .pkt_count(pkt_count), .byte_count(byte_count), .stall_seen(stall_seen)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0, n_total = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // expected packets, popped by the monitor
   int         exp_da[$];
   int         exp_len[$];
   logic [7:0] exp_b[$];
   // producer: {last, byte} and number of ready windows to withhold it
   logic [8:0] pq[$];
   int         pd[$];
   logic [7:0] pk_b[16];
   int         pk_d[16];

   int last_start, last_end, last_first_pay, last_stalls, last_max_run, last_dr;

   task automatic queue_pkt(input int da, input int len, input bit with_exp);
      for (int i = 0; i < len; i++) begin
         pq.push_back({(i == len - 1) ? 1'b1 : 1'b0, pk_b[i]});
         pd.push_back(pk_d[i]);
         if (with_exp) exp_b.push_back(pk_b[i]);
      end
      if (with_exp) begin
         exp_da.push_back(da);
         exp_len.push_back(len);
      end
   endtask

   task automatic send_cmd(input int da, output int hs);
      int t;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_da    = 4'(da);
      t = 0;
      while (!cmd_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) chk("cmd_handshake_timeout", 1, 0);
      hs = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((exp_da.size() != 0 || busy) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", (t >= 5000) ? 1 : 0, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // producer
   initial begin
      bit pend;
      pend = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pq.delete();
            pd.delete();
            pend = 0;
            data_valid = 1'b0;
            continue;
         end
         if (pend) begin
            void'(pq.pop_front());
            void'(pd.pop_front());
         end
         data_valid = 1'b0;
         if (pq.size() > 0) begin
            if (pd[0] > 0) begin
               if (data_ready) pd[0] = pd[0] - 1;
            end else begin
               data_valid = 1'b1;
               data_byte  = pq[0][7:0];
               data_last  = pq[0][8];
            end
         end
         pend = data_valid && data_ready;
      end
   end

   // monitor: collect each frame, decode it, compare with the scoreboard head
   initial begin
      bit rv[$], rd[$];
      bit in_f;
      int dr, st_c, fp, da, bi, run, maxrun, stalls, fmt_bad, eda, elen, mism;
      logic [7:0] got[$];
      logic [7:0] cur, eb;
      in_f = 0; dr = 0; st_c = 0; fp = -1;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_f = 0;
            continue;
         end
         if (!in_f) begin
            if (frame_n == 1'b0) begin
               in_f = 1; rv.delete(); rd.delete(); dr = 0; st_c = cyc; fp = -1;
            end else begin
               continue;
            end
         end
         if (frame_n && valid_n) begin
            chk("frame_abort", 1, 0);
            in_f = 0;
            continue;
         end
         rv.push_back(valid_n);
         rd.push_back(din);
         if (data_ready) dr++;
         if (!valid_n && fp < 0) fp = cyc;
         if (!valid_n && frame_n) begin
            in_f = 0;
            fmt_bad = 0; da = 0; bi = 0; run = 0; maxrun = 0; stalls = 0; cur = '0;
            got.delete();
            for (int i = 0; i < rv.size(); i++) begin
               if (i < ADDR_W) begin
                  if (!rv[i]) fmt_bad++;
                  da = da | (int'(rd[i]) << i);
               end else if (i < ADDR_W + PAD_CYCLES) begin
                  if (!rv[i] || !rd[i]) fmt_bad++;
               end else if (!rv[i]) begin
                  cur[bi] = rd[i];
                  bi++;
                  run++;
                  if (run > maxrun) maxrun = run;
                  if (bi == 8) begin
                     got.push_back(cur);
                     bi = 0;
                  end
               end else begin
                  if (!rd[i]) fmt_bad++;
                  stalls++;
                  run = 0;
               end
            end
            if (bi != 0) fmt_bad++;
            chk("frame_format", fmt_bad, 0);
            last_start = st_c; last_end = cyc; last_first_pay = fp;
            last_stalls = stalls; last_max_run = maxrun; last_dr = dr;
            if (exp_da.size() == 0) begin
               chk("unexpected_frame", 1, 0);
            end else begin
               eda  = exp_da.pop_front();
               elen = exp_len.pop_front();
               mism = 0;
               for (int k = 0; k < elen; k++) begin
                  eb = exp_b.pop_front();
                  if (k >= got.size() || got[k] !== eb) mism++;
               end
               chk("dest_addr", da, eda);
               chk("payload_len", got.size(), elen);
               chk("payload_mismatches", mism, 0);
            end
         end
      end
   end

   initial begin
      int hs, hs2, e1, t, len;
      #2 reset = 1'b1;
      #3 chk("reset_outputs", {frame_n, valid_n, din, cmd_ready, data_ready, busy}, 6'b110000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_cmd_ready", {cmd_ready, busy, frame_n}, 3'b101);

      // single byte 0xA5 to da=3
      pk_b[0] = 8'hA5; pk_d[0] = 0;
      queue_pkt(3, 1, 1);
      send_cmd(3, hs);
      t = 0;
      while (!(!valid_n && frame_n) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("t1_frame_end_seen", (t < 200) ? 1 : 0, 1);
      @(negedge clk);
      chk("t1_gap_state", {frame_n, cmd_ready}, 2'b10);
      @(negedge clk);
      chk("t1_idle_after_gap", cmd_ready, 1);
      wait_done();
      chk("t1_addr_latency", last_start, hs + 1);
      chk("t1_payload_latency", last_first_pay, hs + ADDR_W + PAD_CYCLES + 1);
      chk("t1_frame_span", last_end - last_start + 1, ADDR_W + PAD_CYCLES + 8);

      // three bytes back to back
      pk_b[0] = 8'h01; pk_b[1] = 8'h02; pk_b[2] = 8'hFF;
      pk_d[0] = 0; pk_d[1] = 0; pk_d[2] = 0;
      queue_pkt(10, 3, 1);
      send_cmd(10, hs);
      wait_done();
      chk("t2_valid_run", last_max_run, 24);
      chk("t2_ready_pulses", last_dr, 3);
      chk("t2_no_stall", last_stalls, 0);
`ifdef ROUTER_TX_STATS_EN
      chk("t2_stall_seen_clear", stall_seen, 0);
`endif

      // stall of three cycles before the second byte
      pk_b[0] = 8'h5A; pk_b[1] = 8'hC3; pk_d[0] = 0; pk_d[1] = 3;
      queue_pkt(5, 2, 1);
      send_cmd(5, hs);
      wait_done();
      chk("t3_stall_cycles", last_stalls, 3);
`ifdef ROUTER_TX_STATS_EN
      chk("t3_stall_seen", stall_seen, 1);
`endif

      // asynchronous reset on the 4th payload bit
      pk_b[0] = 8'h3C; pk_b[1] = 8'h99; pk_d[0] = 0; pk_d[1] = 0;
      queue_pkt(15, 2, 0);
      send_cmd(15, hs);
      t = 0;
      while (valid_n && t < 200) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk("t4_mid_payload", {valid_n, din}, 2'b01);
      #2 reset = 1'b1;
      #1 chk("t4_async_reset", {frame_n, valid_n, din, busy, cmd_ready, data_ready}, 6'b110000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      pk_b[0] = 8'h81; pk_b[1] = 8'h7E; pk_d[0] = 0; pk_d[1] = 1;
      queue_pkt(7, 2, 1);
      send_cmd(7, hs);
      wait_done();
      chk("t4_after_reset_start", last_start, hs + 1);

      // cmd_valid held across two packets
      pk_b[0] = 8'h96; pk_d[0] = 0;
      queue_pkt(9, 1, 1);
      pk_b[0] = 8'h44; pk_b[1] = 8'hE1; pk_d[0] = 0; pk_d[1] = 0;
      queue_pkt(6, 2, 1);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_da    = 4'd9;
      t = 0;
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      hs = cyc;
      @(negedge clk);
      cmd_da = 4'd6;
      t = 0;
      while (!cmd_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("t5_second_handshake_seen", (t < 500) ? 1 : 0, 1);
      hs2 = cyc;
      e1  = last_end;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("t5_gap_to_handshake", hs2 - e1, GAP_CYCLES + 1);
      wait_done();
      chk("t5_next_addr_latency", last_start, hs2 + 1);

      // five two-byte packets after a fresh reset
      pulse_reset();
      for (int p = 0; p < 5; p++) begin
         pk_b[0] = 8'($urandom); pk_b[1] = 8'($urandom);
         pk_d[0] = 0; pk_d[1] = $urandom_range(0, 2);
         queue_pkt(p + 1, 2, 1);
         send_cmd(p + 1, hs);
         wait_done();
      end
`ifdef ROUTER_TX_STATS_EN
      chk("t6_pkt_count", pkt_count, 5);
      chk("t6_byte_count", byte_count, 10);
`endif

      // random packets; next cmd is raised while the previous packet is in flight
      for (int p = 0; p < 20; p++) begin
         len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) begin
            pk_b[i] = 8'($urandom);
            pk_d[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         end
         t = $urandom_range(0, 15);
         queue_pkt(t, len, 1);
         send_cmd(t, hs);
      end
      wait_done();
      chk("producer_drained", pq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
